interrupt_controller: RTL

Multi-channel interrupt controller placed in front of the CPU's single interrupt input. It latches up to CHANNELS request lines, masks them, and arbitrates among them by fixed or round-robin priority. It drives the CPU's `irq`/`intAddr`/`intData` and consumes `turnOffIRQ`. Configuration registers are memory-mapped on the CPU data bus.

---
 rtl/interrupt_controller_pkg.sv | 24 ++
 rtl/interrupt_controller_priority_picker.sv | 34 +++
 rtl/interrupt_controller.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/interrupt_controller_pkg.sv
// rtl/interrupt_controller_pkg.sv - shared constants for the interrupt controller and its bench
package interrupt_controller_pkg;

    // Register offsets within the four-word window
    localparam logic [1:0] INTC_MASK    = 2'd0;
    localparam logic [1:0] INTC_PENDING = 2'd1;
    localparam logic [1:0] INTC_EDGE    = 2'd2;
    localparam logic [1:0] INTC_ACTIVE  = 2'd3;

    // FSM encodings
    localparam logic [1:0] INTC_IDLE    = 2'd0;
    localparam logic [1:0] INTC_REQUEST = 2'd1;
    localparam logic [1:0] INTC_GAP     = 2'd2;

    // Arbitration modes
    localparam bit INTC_MODE_FIXED = 1'b0;
    localparam bit INTC_MODE_RR    = 1'b1;

    // Channel index width; a single channel still needs one bit
    function automatic int intc_idx_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/interrupt_controller_priority_picker.sv
// rtl/interrupt_controller_priority_picker.sv - combinational fixed / round-robin winner selection
module priority_picker
    import interrupt_controller_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int IDXW     = intc_idx_width(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req_i,
    input  logic [IDXW-1:0]     last_i,
    input  logic                rr_mode_i,
    output logic                valid_o,
    output logic [IDXW-1:0]     winner_o
);

    // Scan from lowest priority to highest so the last hit taken is the winner
    always_comb begin
        valid_o  = |req_i;
        winner_o = '0;
        if (rr_mode_i == INTC_MODE_RR) begin
            for (int i = CHANNELS; i >= 1; i--) begin
                if (req_i[(int'(last_i) + i) % CHANNELS]) begin
                    winner_o = IDXW'((int'(last_i) + i) % CHANNELS);
                end
            end
        end else begin
            for (int i = CHANNELS - 1; i >= 0; i--) begin
                if (req_i[i]) begin
                    winner_o = IDXW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - masked, edge/level interrupt controller with memory-mapped registers
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int           M             = 16,
    parameter int           N             = 32,
    parameter int           CHANNELS      = 8,
    parameter logic [N-1:0] BASE_ADDR     = 32'hFFFF1010,
    parameter logic [N-1:0] VECTOR_BASE   = 32'h00001000,
    parameter int           VECTOR_STRIDE = 4,
    parameter int           RR_MODE       = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] irqIn,
    output logic                irq,
    input  logic                turnOffIRQ,
    output logic [N-1:0]        intAddr,
    output logic [M-1:0]        intData,
    input  logic [N-1:0]        busAddr,
    input  logic [M-1:0]        busWrite,
    input  logic                busWE,
    output logic [M-1:0]        busRead,
    output logic                busHit
);

    localparam int IDXW    = intc_idx_width(CHANNELS);
    localparam int ACT_BIT = (M > 15) ? 15 : M - 1;

    logic [CHANNELS-1:0] mask_q, mask_d;
    logic [CHANNELS-1:0] pending_q, pending_d;
    logic [CHANNELS-1:0] edge_q, edge_d;
    logic [CHANNELS-1:0] irq_prev_q;
    logic [1:0]          state_q, state_d;
    logic [IDXW-1:0]     cur_q, cur_d;
    logic [IDXW-1:0]     last_q, last_d;
    logic                irq_q, irq_d;
    logic [N-1:0]        int_addr_q, int_addr_d;
    logic [M-1:0]        int_data_q, int_data_d;

    logic [N-1:0]        bus_off;
    logic [1:0]          reg_sel;
    logic                reg_we;
    logic                ack;
    logic [CHANNELS-1:0] w1c_clr;
    logic [CHANNELS-1:0] ack_clr;
    logic [CHANNELS-1:0] edge_set;
    logic                pick_valid;
    logic [IDXW-1:0]     pick_idx;
    logic [M-1:0]        active_v;

    // Window decode: the subtraction wraps, so one unsigned compare covers the range
    assign bus_off = busAddr - BASE_ADDR;
    assign busHit  = (bus_off < N'(4));
    assign reg_sel = bus_off[1:0];
    assign reg_we  = busWE & busHit;

    assign ack      = (state_q == INTC_REQUEST) && turnOffIRQ;
    assign w1c_clr  = (reg_we && reg_sel == INTC_PENDING) ? busWrite[CHANNELS-1:0] : '0;
    assign ack_clr  = ack ? (CHANNELS'(1) << cur_q) : '0;
    assign edge_set = irqIn & ~irq_prev_q;

    // Register file next state; edge channels set-over-clear, level channels track the line
    always_comb begin
        mask_d    = (reg_we && reg_sel == INTC_MASK) ? busWrite[CHANNELS-1:0] : mask_q;
        edge_d    = (reg_we && reg_sel == INTC_EDGE) ? busWrite[CHANNELS-1:0] : edge_q;
        pending_d = (edge_q & (edge_set | (pending_q & ~(w1c_clr | ack_clr))))
                  | (~edge_q & irqIn);
    end

    priority_picker #(
        .CHANNELS (CHANNELS),
        .IDXW     (IDXW)
    ) u_picker (
        .req_i     (pending_q & mask_q),
        .last_i    (last_q),
        .rr_mode_i (RR_MODE != 0),
        .valid_o   (pick_valid),
        .winner_o  (pick_idx)
    );

    // Presentation FSM: latch a winner, hold until acknowledged, then idle one cycle
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        last_d     = last_q;
        irq_d      = irq_q;
        int_addr_d = int_addr_q;
        int_data_d = int_data_q;
        case (state_q)
            INTC_IDLE: begin
                if (pick_valid) begin
                    cur_d      = pick_idx;
                    irq_d      = 1'b1;
                    int_addr_d = VECTOR_BASE + N'(VECTOR_STRIDE) * N'(pick_idx);
                    int_data_d = M'(pick_idx);
                    state_d    = INTC_REQUEST;
                end
            end
            INTC_REQUEST: begin
                if (turnOffIRQ) begin
                    irq_d      = 1'b0;
                    int_addr_d = '0;
                    int_data_d = '0;
                    last_d     = cur_q;
                    state_d    = INTC_GAP;
                end
            end
            INTC_GAP: state_d = INTC_IDLE;
            default:  state_d = INTC_IDLE;
        endcase
    end

    // State registers with synchronous reset; round-robin starts from channel 0
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q     <= '0;
            pending_q  <= '0;
            edge_q     <= '0;
            irq_prev_q <= '0;
            state_q    <= INTC_IDLE;
            cur_q      <= '0;
            last_q     <= IDXW'(CHANNELS - 1);
            irq_q      <= 1'b0;
            int_addr_q <= '0;
            int_data_q <= '0;
        end else begin
            mask_q     <= mask_d;
            pending_q  <= pending_d;
            edge_q     <= edge_d;
            irq_prev_q <= irqIn;
            state_q    <= state_d;
            cur_q      <= cur_d;
            last_q     <= last_d;
            irq_q      <= irq_d;
            int_addr_q <= int_addr_d;
            int_data_q <= int_data_d;
        end
    end

    // ACTIVE word: outstanding flag on the top status bit, channel number in the low nibble
    always_comb begin
        active_v          = '0;
        active_v[3:0]     = 4'(cur_q);
        active_v[ACT_BIT] = (state_q == INTC_REQUEST);
    end

    // Combinational read mux, zero outside the window
    always_comb begin
        busRead = '0;
        if (busHit) begin
            case (reg_sel)
                INTC_MASK:    busRead = M'(mask_q);
                INTC_PENDING: busRead = M'(pending_q);
                INTC_EDGE:    busRead = M'(edge_q);
                default:      busRead = active_v;
            endcase
        end
    end

    assign irq     = irq_q;
    assign intAddr = int_addr_q;
    assign intData = int_data_q;

endmodule
